// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_BRANCH,
    S_TRAP
  } ctrl_state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_PASSB  = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Dispatch out of DECODE; anything not in the supported set traps.
  function automatic ctrl_state_e decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE:      decode_next = S_MEMADR;
      OP_OP:                  decode_next = S_EXECR;
      OP_OPIMM:               decode_next = S_EXECI;
      OP_BRANCH:              decode_next = S_BRANCH;
      OP_JAL:                 decode_next = S_JAL;
      OP_JALR:                decode_next = S_JALR;
      OP_LUI:                 decode_next = S_LUI;
      OP_AUIPC:               decode_next = S_ALUWB;
      OP_SYSTEM, OP_MISC_MEM: decode_next = S_FETCH;
      default:                decode_next = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format select, decoded purely from the opcode so the extender
// is valid in every state.
module imm_src_dec
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:           ImmSrc = IMM_S;
      OP_BRANCH:          ImmSrc = IMM_B;
      OP_JAL:             ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC:   ImmSrc = IMM_U;
      default:            ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV32I core plus retired-instruction counter.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE | ALUOut <= OldPC+imm, dispatch on opcode
//   MEMADR | ALUOut <= rs1+imm (load/store address)
//   MEMRD  | load request at ALUOut, wait for mem_ready
//   MEMWB  | rd <= read data
//   MEMWR  | store request at ALUOut, wait for mem_ready
//   EXECR  | ALUOut <= rs1 op rs2
//   EXECI  | ALUOut <= rs1 op imm
//   LUI    | ALUOut <= imm
//   ALUWB  | rd <= ALUOut
//   JALR   | ALUOut <= rs1+imm (jump target)
//   JAL    | PC <= ALUOut, ALUOut <= OldPC+4
//   BRANCH | compare rs1/rs2, PC <= ALUOut if taken
//   TRAP   | unsupported opcode, parked until reset
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  logic        retire;

  imm_src_dec u_imm_src_dec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  // An instruction retires exactly when control returns to FETCH from elsewhere.
  assign retire = (state != S_FETCH) && (state_nxt == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) begin
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state == S_TRAP) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        state_nxt = decode_next(op);
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_PASSB;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_JAL;
      end
      S_JAL: begin
        // Target already sits in ALUOut; the ALU meanwhile forms the link value.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_BRANCH;
        ResultSrc = RES_ALUOUT;
        PCWrite   = branch_taken;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_TRAP;
      end
    endcase

    // Reset is synchronous, so the state may still be mid-instruction: mask side effects now.
    if (reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control words and retire count, which a negedge checker compares.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  alu;
    logic [1:0]  res;
    logic [2:0]  imm;
    logic        illegal;
    logic [31:0] instret;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [31:0] instret;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .MemWrite     (MemWrite),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ResultSrc    (ResultSrc),
    .ImmSrc       (ImmSrc),
    .illegal      (illegal),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ctrl_t       exp_w;
  logic        exp_rst = 1'b0;
  logic        chk_en = 1'b0;
  string       exp_nm = "";
  int unsigned m_instret = 0;
  logic        m_illegal = 1'b0;

  ctrl_t act;
  assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal, instret};

  // Observed instruction lengths and a few event counts, pinned by literals at the end.
  int lens[$];
  int cyc = 0;
  logic [31:0] last_instret = 32'd0;
  int memrd_cycles = 0;
  int load_wb = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (exp_rst) begin
        if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite} != 5'b0) begin
          errors++;
          $display("FAIL %s: enables in reset got %b want 00000", exp_nm,
                   {mem_req, MemWrite, IRWrite, PCWrite, RegWrite});
        end
        cyc = 0;
        last_instret = 32'd0;
      end else begin
        if (act !== exp_w) begin
          errors++;
          $display("FAIL %s: got req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b A=%b B=%b op=%b res=%b imm=%b ill=%b ret=%0d want req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b A=%b B=%b op=%b res=%b imm=%b ill=%b ret=%0d",
                   exp_nm, act.mem_req, act.MemWrite, act.AdrSrc, act.IRWrite, act.PCWrite,
                   act.RegWrite, act.a, act.b, act.alu, act.res, act.imm, act.illegal, act.instret,
                   exp_w.mem_req, exp_w.MemWrite, exp_w.AdrSrc, exp_w.IRWrite, exp_w.PCWrite,
                   exp_w.RegWrite, exp_w.a, exp_w.b, exp_w.alu, exp_w.res, exp_w.imm,
                   exp_w.illegal, exp_w.instret);
        end
        if (instret != last_instret) begin
          lens.push_back(cyc);
          cyc = 0;
          last_instret = instret;
        end
        cyc++;
        if (mem_req && AdrSrc && !MemWrite) memrd_cycles++;
        if (RegWrite && ResultSrc == 2'b01) load_wb++;
      end
    end
  end

  function automatic ctrl_t cw(input logic mr, input logic mw, input logic adr,
                               input logic irw, input logic pcw, input logic rw,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] alu, input logic [1:0] res);
    ctrl_t c;
    c = '0;
    c.mem_req = mr; c.MemWrite = mw; c.AdrSrc = adr;
    c.IRWrite = irw; c.PCWrite = pcw; c.RegWrite = rw;
    c.a = a; c.b = b; c.alu = alu; c.res = res;
    return c;
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  task automatic step(input string nm, input ctrl_t e, input logic rdy, input logic tk,
                      input logic rst, input logic [6:0] o);
    @(posedge clk);
    #1;
    reset = rst;
    mem_ready = rdy;
    branch_taken = tk;
    op = o;
    e.imm = exp_imm(o);
    e.illegal = m_illegal;
    e.instret = m_instret;
    exp_w = e;
    exp_rst = rst;
    exp_nm = nm;
    chk_en = 1'b1;
  endtask

  // Control words for each phase of an instruction.
  localparam logic [1:0] Z = 2'b00;
  task automatic fetch_decode(input string nm, input logic [6:0] o, input int fw, input logic tk);
    for (int i = 0; i < fw; i++)
      step({nm, ":fetch-wait"}, cw(1,0,0,0,0,0, Z,2'b10,Z,2'b10), 1'b0, tk, 1'b0, o);
    step({nm, ":fetch"},  cw(1,0,0,1,1,0, Z,2'b10,Z,2'b10), 1'b1, tk, 1'b0, o);
    step({nm, ":decode"}, cw(0,0,0,0,0,0, 2'b01,2'b01,Z,Z), 1'b0, tk, 1'b0, o);
  endtask

  task automatic instr(input string nm, input logic [6:0] o, input int fw, input int mw,
                       input logic tk);
    ctrl_t aluwb;
    aluwb = cw(0,0,0,0,0,1, Z,Z,Z,Z);
    fetch_decode(nm, o, fw, tk);
    case (o)
      7'b0110011: begin
        step({nm, ":exec"},  cw(0,0,0,0,0,0, 2'b10,Z,2'b10,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wb"},    aluwb, 1'b0, tk, 1'b0, o);
      end
      7'b0010011: begin
        step({nm, ":exec"},  cw(0,0,0,0,0,0, 2'b10,2'b01,2'b10,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wb"},    aluwb, 1'b0, tk, 1'b0, o);
      end
      7'b0110111: begin
        step({nm, ":lui"},   cw(0,0,0,0,0,0, Z,2'b01,2'b11,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wb"},    aluwb, 1'b0, tk, 1'b0, o);
      end
      7'b0010111: step({nm, ":wb"}, aluwb, 1'b0, tk, 1'b0, o);
      7'b0000011: begin
        step({nm, ":adr"},   cw(0,0,0,0,0,0, 2'b10,2'b01,Z,Z), 1'b0, tk, 1'b0, o);
        for (int i = 0; i < mw; i++)
          step({nm, ":rd-wait"}, cw(1,0,1,0,0,0, Z,Z,Z,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":rd"},    cw(1,0,1,0,0,0, Z,Z,Z,Z), 1'b1, tk, 1'b0, o);
        step({nm, ":memwb"}, cw(0,0,0,0,0,1, Z,Z,Z,2'b01), 1'b0, tk, 1'b0, o);
      end
      7'b0100011: begin
        step({nm, ":adr"},   cw(0,0,0,0,0,0, 2'b10,2'b01,Z,Z), 1'b0, tk, 1'b0, o);
        for (int i = 0; i < mw; i++)
          step({nm, ":wr-wait"}, cw(1,1,1,0,0,0, Z,Z,Z,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wr"},    cw(1,1,1,0,0,0, Z,Z,Z,Z), 1'b1, tk, 1'b0, o);
      end
      7'b1100011:
        step({nm, ":branch"}, cw(0,0,0,0,tk,0, 2'b10,Z,2'b01,Z), 1'b0, tk, 1'b0, o);
      7'b1100111: begin
        step({nm, ":jalr"},  cw(0,0,0,0,0,0, 2'b10,2'b01,Z,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":jal"},   cw(0,0,0,0,1,0, 2'b01,2'b10,Z,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wb"},    aluwb, 1'b0, tk, 1'b0, o);
      end
      7'b1101111: begin
        step({nm, ":jal"},   cw(0,0,0,0,1,0, 2'b01,2'b10,Z,Z), 1'b0, tk, 1'b0, o);
        step({nm, ":wb"},    aluwb, 1'b0, tk, 1'b0, o);
      end
      default: ;
    endcase
    m_instret++;
  endtask

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lens[10];
    exp_lens = '{4, 8, 3, 3, 5, 6, 4, 3, 5, 4};

    step("reset0", '0, 1'b0, 1'b0, 1'b1, 7'd0);
    step("reset1", '0, 1'b0, 1'b0, 1'b1, 7'd0);

    instr("add",   7'b0110011, 0, 0, 1'b0);
    instr("lw",    7'b0000011, 0, 3, 1'b0);
    instr("beq_t", 7'b1100011, 0, 0, 1'b1);
    instr("beq_n", 7'b1100011, 0, 0, 1'b0);
    instr("jalr",  7'b1100111, 0, 0, 1'b0);
    instr("addi",  7'b0010011, 2, 0, 1'b0);
    instr("lui",   7'b0110111, 0, 0, 1'b0);
    instr("auipc", 7'b0010111, 0, 0, 1'b0);
    instr("sw",    7'b0100011, 0, 1, 1'b0);
    instr("jal",   7'b1101111, 0, 0, 1'b0);

    // Store abandoned by reset while its request is still outstanding.
    fetch_decode("sw_rst", 7'b0100011, 0, 1'b0);
    step("sw_rst:adr", cw(0,0,0,0,0,0, 2'b10,2'b01,Z,Z), 1'b0, 1'b0, 1'b0, 7'b0100011);
    step("sw_rst:wr-wait", cw(1,1,1,0,0,0, Z,Z,Z,Z), 1'b0, 1'b0, 1'b0, 7'b0100011);
    step("sw_rst:wr-wait", cw(1,1,1,0,0,0, Z,Z,Z,Z), 1'b0, 1'b0, 1'b0, 7'b0100011);
    step("sw_rst:reset", '0, 1'b0, 1'b0, 1'b1, 7'b0100011);
    m_instret = 0;
    instr("add_after_rst", 7'b0110011, 0, 0, 1'b0);

    // Illegal opcode parks the FSM; illegal sets after the first TRAP cycle and sticks.
    fetch_decode("trap", 7'b1111111, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("trap:park", cw(0,0,0,0,0,0, Z,Z,Z,Z), 1'b1, 1'b1, 1'b0, 7'b1111111);
      m_illegal = 1'b1;
    end
    step("trap:reset", '0, 1'b0, 1'b0, 1'b1, 7'b1111111);
    m_instret = 0;
    m_illegal = 1'b0;
    instr("add_after_trap", 7'b0110011, 0, 0, 1'b0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      lit($sformatf("len%0d", i), (i < lens.size()) ? lens[i] : -1, exp_lens[i]);
    lit("lw_memrd_cycles", memrd_cycles, 4);
    lit("lw_regwrite_rdata", load_wb, 1);
    lit("final_instret", int'(instret), 1);
    lit("final_illegal", int'(illegal), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
